// File: rtl/mealy1011.sv
// Overlapping 1011 sequence detector, oldest bit first.
// Mealy FSM: z flags the fourth bit combinationally.
module mealy1011 (
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic z
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S0;
    end else begin
      unique case (state)
        S0:      state <= x ? S1 : S0;
        S1:      state <= x ? S1 : S2;
        S2:      state <= x ? S3 : S0;
        // a hit keeps its final 1 as the next prefix
        S3:      state <= x ? S1 : S2;
        default: state <= S0;
      endcase
    end
  end

  assign z = (state == S3) && x && !reset;

endmodule

// File: tb/tb_mealy1011.sv
// Directed bench for mealy1011.
// z sampled 1 time unit after each negedge input update.
module tb_mealy1011;

  logic clk;
  logic reset;
  logic x;
  logic z;

  int checks;
  int errors;

  mealy1011 dut (
    .clk  (clk),
    .reset(reset),
    .x    (x),
    .z    (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, required finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    x = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    x = b;
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (z !== 1'b0) begin
      errors++;
      $display("FAIL powerup_z0: z=%b required 0", z);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut.state !== 2'd0) begin
      errors++;
      $display("FAIL powerup_state: state=%0d required 0", dut.state);
    end
    checks++;
    if (z !== 1'b0) begin
      errors++;
      $display("FAIL powerup_z1: z=%b required 0", z);
    end
    x = 1'b1;
    #1;
    checks++;
    if (z !== 1'b0) begin
      errors++;
      $display("FAIL powerup_zx: z=%b required 0", z);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut.state !== 2'd0) begin
      errors++;
      $display("FAIL powerup_state2: state=%0d required 0", dut.state);
    end
    reset = 1'b0;
    x = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] v;
    logic [3:0] e;
    v = 4'b1011;
    e = 4'b0001;
    do_reset();
    for (int i = 3; i >= 0; i--) begin
      drive_bit(v[i]);
      checks++;
      if (z !== e[i]) begin
        errors++;
        $display("FAIL basic_z bit%0d: z=%b required %b", 4 - i, z, e[i]);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut.state !== 2'd1) begin
      errors++;
      $display("FAIL basic_state: state=%0d required 1", dut.state);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] v;
    logic [6:0] e;
    v = 7'b1011011;
    e = 7'b0001001;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      drive_bit(v[i]);
      checks++;
      if (z !== e[i]) begin
        errors++;
        $display("FAIL overlap_z bit%0d: z=%b required %b", 7 - i, z, e[i]);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut.state !== 2'd1) begin
      errors++;
      $display("FAIL overlap_state: state=%0d required 1", dut.state);
    end
  endtask

  task automatic test_near_miss();
    logic [4:0] va;
    logic [4:0] vb;
    va = 5'b10011;
    vb = 5'b11010;
    do_reset();
    for (int i = 4; i >= 0; i--) begin
      drive_bit(va[i]);
      checks++;
      if (z !== 1'b0) begin
        errors++;
        $display("FAIL miss_a_z bit%0d: z=%b required 0", 5 - i, z);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut.state !== 2'd1) begin
      errors++;
      $display("FAIL miss_a_state: state=%0d required 1", dut.state);
    end
    do_reset();
    for (int i = 4; i >= 0; i--) begin
      drive_bit(vb[i]);
      checks++;
      if (z !== 1'b0) begin
        errors++;
        $display("FAIL miss_b_z bit%0d: z=%b required 0", 5 - i, z);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut.state !== 2'd2) begin
      errors++;
      $display("FAIL miss_b_state: state=%0d required 2", dut.state);
    end
  endtask

  task automatic test_stream();
    logic [15:0] v;
    logic [15:0] e;
    v = 16'b0010110110010110;
    e = 16'b0000010010000010;
    do_reset();
    for (int i = 15; i >= 0; i--) begin
      drive_bit(v[i]);
      checks++;
      if (z !== e[i]) begin
        errors++;
        $display("FAIL stream_z bit%0d: z=%b required %b", 16 - i, z, e[i]);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut.state !== 2'd2) begin
      errors++;
      $display("FAIL stream_state: state=%0d required 2", dut.state);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    logic [7:0] e;
    v = 8'b10111011;
    e = 8'b00010001;
    do_reset();
    for (int i = 7; i >= 0; i--) begin
      drive_bit(v[i]);
      checks++;
      if (z !== e[i]) begin
        errors++;
        $display("FAIL b2b_z bit%0d: z=%b required %b", 8 - i, z, e[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [2:0] v;
    v = 3'b101;
    do_reset();
    for (int i = 2; i >= 0; i--) begin
      drive_bit(v[i]);
      checks++;
      if (z !== 1'b0) begin
        errors++;
        $display("FAIL midrst_z bit%0d: z=%b required 0", 3 - i, z);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    x = 1'b1;
    #1;
    checks++;
    if (z !== 1'b0) begin
      errors++;
      $display("FAIL midrst_zrst: z=%b required 0", z);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut.state !== 2'd0) begin
      errors++;
      $display("FAIL midrst_state: state=%0d required 0", dut.state);
    end
    @(negedge clk);
    reset = 1'b0;
    x = 1'b1;
    #1;
    checks++;
    if (z !== 1'b0) begin
      errors++;
      $display("FAIL midrst_zrel: z=%b required 0", z);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut.state !== 2'd1) begin
      errors++;
      $display("FAIL midrst_fresh: state=%0d required 1", dut.state);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    x = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_overlap();
    test_near_miss();
    test_stream();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
